// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE row sequencer and the PEs it drives.
package pe_ctrl_pkg;

    localparam int unsigned WSEL_W   = 2;
    localparam int unsigned NUM_WBUF = 4;
    localparam int unsigned MAX_PE   = 64;
    localparam int unsigned IDX_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_FEED = 3'd2,
        ST_MAC  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // One-hot decode of a PE index; callers truncate to their row width.
    function automatic logic [MAX_PE-1:0] onehot(input logic [IDX_W-1:0] idx);
        return MAX_PE'(1) << idx;
    endfunction

endpackage

// File: rtl/pe_row_ctrl.sv
// Row sequencer: loads PE weight buffers, then streams pixels into PE0 and
// steps weight_sel through the multiply phases, tagging each product.
module pe_row_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned PIX_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_skip_load,
    input  logic [PIX_W-1:0]  cfg_npix,
    input  logic [1:0]        cfg_nsel_m1,
    input  logic              w_valid,
    input  logic [7:0]        w_data,
    output logic              w_ready,
    input  logic              i_valid,
    input  logic [7:0]        i_data,
    output logic              i_ready,
    output logic [7:0]        weight_load,
    output logic [NUM_PE-1:0] weight_load_en,
    output logic [1:0]        weight_load_sel,
    output logic [7:0]        imap_in,
    output logic              pipe_en,
    output logic              pe_en,
    output logic [1:0]        weight_sel,
    output logic              prod_valid,
    output logic [1:0]        prod_sel,
    output logic              prod_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PE_IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [PE_IDX_W-1:0] LAST_PE  = PE_IDX_W'(NUM_PE - 1);
    localparam logic [WSEL_W-1:0]   LAST_SEL = WSEL_W'(NUM_WBUF - 1);

    state_e              state_q, state_d;
    logic [PE_IDX_W-1:0] pe_idx_q, pe_idx_d;
    logic [WSEL_W-1:0]   sel_idx_q, sel_idx_d;
    logic [WSEL_W-1:0]   phase_q, phase_d;
    logic [WSEL_W-1:0]   nsel_m1_q, nsel_m1_d;
    logic [PIX_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [PIX_W-1:0]    npix_q, npix_d;
    logic                prod_valid_q, prod_valid_d;
    logic [WSEL_W-1:0]   prod_sel_q, prod_sel_d;
    logic                prod_last_q, prod_last_d;
    logic                last_phase_c;
    logic                last_pix_c;

    // State, counters and product tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pe_idx_q     <= '0;
            sel_idx_q    <= '0;
            phase_q      <= '0;
            nsel_m1_q    <= '0;
            pix_cnt_q    <= '0;
            npix_q       <= '0;
            prod_valid_q <= 1'b0;
            prod_sel_q   <= '0;
            prod_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pe_idx_q     <= pe_idx_d;
            sel_idx_q    <= sel_idx_d;
            phase_q      <= phase_d;
            nsel_m1_q    <= nsel_m1_d;
            pix_cnt_q    <= pix_cnt_d;
            npix_q       <= npix_d;
            prod_valid_q <= prod_valid_d;
            prod_sel_q   <= prod_sel_d;
            prod_last_q  <= prod_last_d;
        end
    end

    assign last_phase_c = (phase_q == nsel_m1_q);
    assign last_pix_c   = (pix_cnt_q == (npix_q - PIX_W'(1)));

    // Next state, counter updates and row control outputs
    always_comb begin
        state_d         = state_q;
        pe_idx_d        = pe_idx_q;
        sel_idx_d       = sel_idx_q;
        phase_d         = phase_q;
        nsel_m1_d       = nsel_m1_q;
        pix_cnt_d       = pix_cnt_q;
        npix_d          = npix_q;
        w_ready         = 1'b0;
        i_ready         = 1'b0;
        weight_load     = '0;
        weight_load_en  = '0;
        weight_load_sel = '0;
        imap_in         = '0;
        pipe_en         = 1'b0;
        pe_en           = 1'b0;
        weight_sel      = '0;
        done            = 1'b0;
        busy            = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    npix_d    = cfg_npix;
                    nsel_m1_d = cfg_nsel_m1;
                    if (!cfg_skip_load) begin
                        state_d = ST_LOAD;
                    end else if (cfg_npix == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end

            ST_LOAD: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    weight_load     = w_data;
                    weight_load_en  = NUM_PE'(onehot(IDX_W'(pe_idx_q)));
                    weight_load_sel = sel_idx_q;
                    if (sel_idx_q == LAST_SEL) begin
                        sel_idx_d = '0;
                        if (pe_idx_q == LAST_PE) begin
                            pe_idx_d = '0;
                            state_d  = (npix_q == '0) ? ST_DONE : ST_FEED;
                        end else begin
                            pe_idx_d = pe_idx_q + PE_IDX_W'(1);
                        end
                    end else begin
                        sel_idx_d = sel_idx_q + WSEL_W'(1);
                    end
                end
            end

            ST_FEED: begin
                i_ready = 1'b1;
                imap_in = i_data;
                pipe_en = i_valid;
                if (i_valid) begin
                    phase_d = '0;
                    state_d = ST_MAC;
                end
            end

            ST_MAC: begin
                pe_en      = 1'b1;
                weight_sel = phase_q;
                phase_d    = phase_q + WSEL_W'(1);
                if (last_phase_c) begin
                    phase_d   = '0;
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    state_d   = last_pix_c ? ST_DONE : ST_FEED;
                end
            end

            ST_DONE: begin
                done      = 1'b1;
                pe_idx_d  = '0;
                sel_idx_d = '0;
                phase_d   = '0;
                pix_cnt_d = '0;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tags line up with the PE product register, one cycle behind pe_en
    always_comb begin
        prod_valid_d = pe_en;
        prod_sel_d   = weight_sel;
        prod_last_d  = pe_en && last_phase_c && last_pix_c;
    end

    assign prod_valid = prod_valid_q;
    assign prod_sel   = prod_sel_q;
    assign prod_last  = prod_last_q;

endmodule
